input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Multi-channel synchronizer and debouncer for raw board inputs: push-buttons, slide switches, GPIO inputs.
- Sits directly upstream of the board top level. It replaces the single-flop reset "debounce" and feeds clean levels into the SoC's reset and gpio_input.
- Each channel has three stages:
  - a 2-flop synchronizer,
  - a stability counter,
  - a registered debounced level with one-cycle rise/fall event pulses.

Parameters:
- WIDTH, 3, number of independent input channels.
- DEBOUNCE_CYCLES, 120000, consecutive clock cycles a new level must persist before it is accepted (10 ms at 12 MHz). Legal range 1..2^24.
- RESET_VALUE, {WIDTH{1'b0}}, per-channel value loaded into synchronizer and debounced registers during reset.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately; release is synchronous to the design.
- raw_in  input  WIDTH  unsynchronized pin levels.
- debounced  output  WIDTH  stable, synchronized level per channel.
- rise  output  WIDTH  one-cycle pulse when debounced[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when debounced[i] goes 1->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync0, sync1, debounced load RESET_VALUE.
  - All counters = 0.
  - rise = fall = 0.
- Reset asserted mid-count: discards any partial count, with no pulse. After release, counting restarts from 0 against RESET_VALUE.
- Channels are fully independent; no shared counter.
- Synchronizer: sync0[i] <= raw_in[i]; sync1[i] <= sync0[i]. Only sync1 is used downstream.
- Counter width: clog2(DEBOUNCE_CYCLES)+1 bits; it never wraps.
- Per channel, each rising edge, state decision:
  - MATCH (sync1 == debounced): count <= 0; rise/fall <= 0.
  - PENDING (sync1 != debounced, count < DEBOUNCE_CYCLES-1): count <= count+1; rise/fall <= 0.
  - ACCEPT (sync1 != debounced, count == DEBOUNCE_CYCLES-1):
    - debounced <= sync1; count <= 0.
    - rise <= sync1, fall <= ~sync1, both for this cycle only.
- Latency: raw_in first captured at edge k and held constant thereafter -> debounced and pulse update at edge k+1+DEBOUNCE_CYCLES.
  - DEBOUNCE_CYCLES=1 gives a plain 2-flop synchronizer plus a 1-cycle register, i.e. update at edge k+2.
- Glitch rejection: any return to MATCH before ACCEPT clears the count. A pulse train whose high time is shorter than DEBOUNCE_CYCLES never changes debounced, however many pulses occur.
- Pulse timing:
  - rise and fall are registered and never both 1 on the same channel.
  - Each pulse is asserted exactly in the cycle debounced holds its new value.
- Simultaneous events on different channels are handled independently; pulses may coincide across channels.
- No combinational path from raw_in to any output.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=3, RESET_VALUE=3'b000 unless noted):
- Reset: hold reset=0 with raw_in=3'b111 -> debounced=000, rise=fall=000 throughout. Release, raw_in stays 111 -> debounced=111 and rise=111 for one cycle, 6 edges after release (k+5).
- Clean step: raw_in[0] 0->1, captured at edge k -> debounced[0]=1 and rise[0]=1 at edge k+5 only; fall=0. Then 1->0 -> fall[0] single-cycle pulse after the same latency.
- Glitch: raw_in[1] high for 3 cycles, low for 1, high for 3, repeated 10 times -> debounced[1] stays 0, no pulses. Then hold high 4+ cycles -> rise[1] once.
- Independence: raw_in[0] and raw_in[2] rise on the same edge, raw_in[1] bounces -> rise=3'b101 in one cycle; channel 1 unaffected.
- Reset mid-count: raw_in[2]=1 for 3 cycles, then pulse reset=0 asynchronously between edges -> outputs clear immediately, no pulse. Full latency restarts after release.
- Parameter corners:
  - DEBOUNCE_CYCLES=1 -> debounced follows raw_in with exactly 2-edge latency.
  - RESET_VALUE=3'b111 with raw_in=111 -> no pulses after reset release.

Source files
------------

// File: rtl/input_debouncer.sv
// input_debouncer
//   Multi-channel synchronizer and debouncer for raw board inputs
//   (push-buttons, slide switches, GPIO). Each channel synchronizes its pin
//   through two flops, then accepts a new level only after it has been seen
//   for DEBOUNCE_CYCLES consecutive clocks. Each accepted change produces a
//   one-cycle rise or fall pulse.
//
//   Ports:
//     clock      in   1      system clock, all state on rising edge
//     reset      in   1      asynchronous active-low reset
//     raw_in     in   WIDTH  unsynchronized pin levels
//     debounced  out  WIDTH  stable, synchronized level per channel
//     rise       out  WIDTH  one-cycle pulse on debounced 0->1
//     fall       out  WIDTH  one-cycle pulse on debounced 1->0

// Single-channel slice: 2-flop synchronizer, stability counter, and
// registered level/pulse outputs.
module input_debouncer_ch #(
   parameter int   DEBOUNCE_CYCLES = 120000,
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   output logic deb_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync0_q, sync1_q;
   logic          deb_q, deb_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only advances while below LAST and is cleared on accept or
   // on any return to the debounced level, so it can never wrap.
   always_comb begin
      cnt_d  = '0;
      deb_d  = deb_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync1_q != deb_q) begin
         if (cnt_q == LAST) begin
            deb_d  = sync1_q;
            rise_d = sync1_q;
            fall_d = ~sync1_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync0_q <= RESET_VALUE;
         sync1_q <= RESET_VALUE;
         deb_q   <= RESET_VALUE;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync0_q <= raw_i;
         sync1_q <= sync0_q;
         deb_q   <= deb_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign deb_o  = deb_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

module input_debouncer #(
   parameter int               WIDTH           = 3,
   parameter int               DEBOUNCE_CYCLES = 120000,
   parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] debounced,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Channels are fully independent: one slice (own counter) per input.
   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      input_debouncer_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VALUE     (RESET_VALUE[g])
      ) u_ch (
         .clock  (clock),
         .reset  (reset),
         .raw_i  (raw_in[g]),
         .deb_o  (debounced[g]),
         .rise_o (rise[g]),
         .fall_o (fall[g])
      );
   end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
//   Three instances share clock/reset/raw_in:
//     a: DEBOUNCE_CYCLES=4, RESET_VALUE=000
//     b: DEBOUNCE_CYCLES=1, RESET_VALUE=000
//     c: DEBOUNCE_CYCLES=4, RESET_VALUE=111
//   A reference model (sample-history window: a level is accepted the first
//   time the last N synchronized samples all differ from the current level)
//   pushes the expected outputs at each rising edge; the monitor pops and
//   compares them on the falling edge.
module tb_input_debouncer;

   typedef struct packed {
      logic [2:0] deb;
      logic [2:0] rise;
      logic [2:0] fall;
   } obs_t;
   typedef obs_t [2:0] exp_t;

   logic       clock;
   logic       reset;
   logic [2:0] raw;
   logic [2:0] deb_w  [3];
   logic [2:0] rise_w [3];
   logic [2:0] fall_w [3];

   int checks   = 0;
   int failures = 0;
   int rise1_cnt = 0;

   exp_t sb[$];

   int         m_n  [3] = '{4, 1, 4};
   logic [2:0] m_rv [3] = '{3'b000, 3'b000, 3'b111};
   logic [2:0] m_s0 [3], m_s1 [3], m_deb [3], m_rise [3], m_fall [3];
   logic [3:0] m_hist [3][3];

   input_debouncer #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .RESET_VALUE(3'b000)) dut_a (
      .clock(clock), .reset(reset), .raw_in(raw),
      .debounced(deb_w[0]), .rise(rise_w[0]), .fall(fall_w[0]));
   input_debouncer #(.WIDTH(3), .DEBOUNCE_CYCLES(1), .RESET_VALUE(3'b000)) dut_b (
      .clock(clock), .reset(reset), .raw_in(raw),
      .debounced(deb_w[1]), .rise(rise_w[1]), .fall(fall_w[1]));
   input_debouncer #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .RESET_VALUE(3'b111)) dut_c (
      .clock(clock), .reset(reset), .raw_in(raw),
      .debounced(deb_w[2]), .rise(rise_w[2]), .fall(fall_w[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      for (int c = 0; c < 3; c++) begin
         m_s0[c]   = m_rv[c];
         m_s1[c]   = m_rv[c];
         m_deb[c]  = m_rv[c];
         m_rise[c] = 3'b000;
         m_fall[c] = 3'b000;
         for (int ch = 0; ch < 3; ch++) m_hist[c][ch] = {4{m_rv[c][ch]}};
      end
   endtask

   task automatic model_edge();
      exp_t e;
      logic v, ok;
      for (int c = 0; c < 3; c++) begin
         for (int ch = 0; ch < 3; ch++) begin
            v = m_s1[c][ch];
            m_hist[c][ch] = {m_hist[c][ch][2:0], v};
            m_rise[c][ch] = 1'b0;
            m_fall[c][ch] = 1'b0;
            ok = 1'b1;
            for (int j = 0; j < m_n[c]; j++)
               if (m_hist[c][ch][j] == m_deb[c][ch]) ok = 1'b0;
            if (ok) begin
               m_deb[c][ch]  = v;
               m_rise[c][ch] = v;
               m_fall[c][ch] = ~v;
            end
         end
         m_s1[c] = m_s0[c];
         m_s0[c] = raw;
         e[c].deb  = m_deb[c];
         e[c].rise = m_rise[c];
         e[c].fall = m_fall[c];
      end
      sb.push_back(e);
   endtask

   // Drive one cycle: raw is stable across the edge; returns at edge+2.
   task automatic cyc(input logic [2:0] r);
      raw = r;
      @(posedge clock);
      if (reset) model_edge();
      #2;
   endtask

   task automatic hold(input logic [2:0] r, input int n);
      for (int i = 0; i < n; i++) cyc(r);
   endtask

   // Asynchronous reset pulse between edges, spanning one falling edge.
   task automatic rst_pulse();
      reset = 1'b0;
      model_reset();
      #1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("async_clr_deb%0d", c),  int'(deb_w[c]),  int'(m_rv[c]));
         chk($sformatf("async_clr_rise%0d", c), int'(rise_w[c]), 0);
         chk($sformatf("async_clr_fall%0d", c), int'(fall_w[c]), 0);
      end
      #4;
      reset = 1'b1;
   endtask

   // Monitor: scoreboard compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            for (int c = 0; c < 3; c++) begin
               chk($sformatf("rst_deb%0d", c),  int'(deb_w[c]),  int'(m_rv[c]));
               chk($sformatf("rst_rise%0d", c), int'(rise_w[c]), 0);
               chk($sformatf("rst_fall%0d", c), int'(fall_w[c]), 0);
            end
         end else if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int c = 0; c < 3; c++) begin
               chk($sformatf("sb_deb%0d", c),  int'(deb_w[c]),  int'(e[c].deb));
               chk($sformatf("sb_rise%0d", c), int'(rise_w[c]), int'(e[c].rise));
               chk($sformatf("sb_fall%0d", c), int'(fall_w[c]), int'(e[c].fall));
            end
            if (rise_w[0][1]) rise1_cnt++;
         end
      end
   end

   initial begin
      int base;
      logic [2:0] r;
      int n;
      reset = 1'b1;
      raw   = 3'b111;
      #1;
      reset = 1'b0;
      model_reset();
      hold(3'b111, 4);
      reset = 1'b1;

      // Reset release with inputs already high.
      for (int i = 1; i <= 7; i++) begin
         cyc(3'b111);
         if (i == 5) chk("rel_deb_early", int'(deb_w[0]), 0);
         if (i == 6) begin
            chk("rel_deb_a",  int'(deb_w[0]),  7);
            chk("rel_rise_a", int'(rise_w[0]), 7);
            chk("rel_deb_b",  int'(deb_w[1]),  7);
            chk("rel_rise_c", int'(rise_w[2]), 0);
         end
         if (i == 7) chk("rel_rise_a_one", int'(rise_w[0]), 0);
      end
      hold(3'b000, 8);

      // Clean step on channel 0.
      for (int i = 1; i <= 8; i++) begin
         cyc(3'b001);
         if (i == 5) chk("step_rise_early", int'(rise_w[0]), 0);
         if (i == 6) chk("step_rise", int'(rise_w[0]), 1);
      end
      for (int i = 1; i <= 8; i++) begin
         cyc(3'b000);
         if (i == 6) chk("step_fall", int'(fall_w[0]), 1);
         if (i == 7) chk("step_fall_one", int'(fall_w[0]), 0);
      end

      // Glitch train on channel 1.
      base = rise1_cnt;
      for (int p = 0; p < 10; p++) begin
         hold(3'b010, 3);
         cyc(3'b000);
      end
      cyc(3'b000);
      chk("glitch_no_rise", rise1_cnt - base, 0);
      chk("glitch_deb", int'(deb_w[0]), 0);
      hold(3'b010, 8);
      chk("glitch_then_rise", rise1_cnt - base, 1);
      hold(3'b000, 8);

      // Independence: ch0/ch2 step together, ch1 bounces every cycle.
      for (int i = 1; i <= 8; i++) begin
         cyc({1'b1, i[0], 1'b1});
         if (i == 6) chk("indep_rise", int'(rise_w[0]), 5);
      end
      chk("indep_deb", int'(deb_w[0]), 5);
      hold(3'b000, 8);

      // Reset in the middle of a count on channel 2.
      hold(3'b100, 3);
      rst_pulse();
      for (int i = 1; i <= 7; i++) begin
         cyc(3'b100);
         if (i == 5) chk("midrst_deb_early", int'(deb_w[0]), 0);
         if (i == 6) chk("midrst_rise", int'(rise_w[0]), 4);
      end
      hold(3'b000, 8);

      // Random levels with random hold times.
      for (int k = 0; k < 40; k++) begin
         r = 3'($urandom_range(0, 7));
         n = $urandom_range(1, 6);
         hold(r, n);
      end
      hold(3'b000, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
